lpbk_engine: RTL

LPBK_ENGINE -- requirements
Module: lpbk_engine

---
 rtl/lpbk_engine.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/lpbk_engine.sv
// lpbk_engine: line-copy loopback engine.
// Reads num_lines source lines (offsets 0..num_lines-1) through a read-request
// port and buffers the in-order responses in a small FIFO. Each buffered line
// is transformed and written to the same offset through a write-request port.
// The run is complete once num_lines write completions have been counted.
//
// Ports
//   clk, reset                 sole rising-edge clock; asynchronous active-low reset
//   start, num_lines, mode,    run launch (level, sampled in IDLE) and run arguments;
//   add_value                  the arguments are latched at launch
//   busy, finish               running (RUN/DRAIN) / sticky run-complete flag
//   rd_req_*                   read request (valid/ready, offset)
//   rd_rsp_valid/data          in-order read response, no back-pressure
//   wr_req_*                   write request (valid/ready, offset, data)
//   wr_rsp_valid               one pulse per completed write
//   rd_count, wr_count         reads issued / write completions in this run
module lpbk_engine #(
  parameter int DATA_W     = 512,
  parameter int OFFSET_W   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OFFSET_W-1:0] num_lines,
  input  logic [1:0]          mode,
  input  logic [31:0]         add_value,
  output logic                busy,
  output logic                finish,
  output logic                rd_req_valid,
  input  logic                rd_req_ready,
  output logic [OFFSET_W-1:0] rd_req_offset,
  input  logic                rd_rsp_valid,
  input  logic [DATA_W-1:0]   rd_rsp_data,
  output logic                wr_req_valid,
  input  logic                wr_req_ready,
  output logic [OFFSET_W-1:0] wr_req_offset,
  output logic [DATA_W-1:0]   wr_req_data,
  input  logic                wr_rsp_valid,
  output logic [OFFSET_W-1:0] rd_count,
  output logic [OFFSET_W-1:0] wr_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LANES = DATA_W / 32;
  localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]    ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    ZERO_CNT = CNT_W'(0);
  localparam logic [OFFSET_W-1:0] ONE_OFF  = OFFSET_W'(1);
  localparam logic [OFFSET_W-1:0] ZERO_OFF = OFFSET_W'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Per-lane data transform; lanes are independent 32-bit words (no carry between lanes).
  function automatic logic [DATA_W-1:0] transform(input logic [DATA_W-1:0] line,
                                                  input logic [1:0]        sel,
                                                  input logic [31:0]       addend);
    logic [DATA_W-1:0] res;
    res = line;
    case (sel)
      2'd0:    res = line;
      2'd1:    res = ~line;
      2'd2: begin
        for (int i = 0; i < LANES; i++) begin
          res[i*32 +: 32] = line[i*32 +: 32] + addend;
        end
      end
      default: res = line;
    endcase
    return res;
  endfunction

  state_t                state;
  state_t                state_nxt;
  logic [OFFSET_W-1:0]   lines;
  logic [1:0]            mode_lat;
  logic [31:0]           add_lat;
  logic [OFFSET_W-1:0]   rd_idx;
  logic [OFFSET_W-1:0]   wr_idx;
  logic [OFFSET_W-1:0]   wr_cnt;
  logic [CNT_W-1:0]      in_flight;
  logic [DATA_W-1:0]     mem [FIFO_DEPTH];
  logic [CNT_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_used;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  launch;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  push;
  logic                  done;

  assign launch     = (state == IDLE) && start;
  assign busy       = (state != IDLE);
  assign fifo_used  = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (fifo_used == DEPTH_C);
  // Responses are only accepted while a run is active; anything left over
  // from an aborted run is dropped.
  assign push       = rd_rsp_valid && busy && !fifo_full;
  assign rd_fire    = rd_req_valid && rd_req_ready;
  assign wr_fire    = wr_req_valid && wr_req_ready;
  assign done       = (state == DRAIN) && (wr_cnt == lines);

  // The read credit (in_flight) counts lines between read accept and write
  // pop, so the FIFO always has room for every outstanding response.
  assign rd_req_valid  = (state == RUN) && (rd_idx < lines) && (in_flight < DEPTH_C);
  assign rd_req_offset = rd_idx;
  assign rd_count      = rd_idx;
  assign wr_req_valid  = !fifo_empty;
  assign wr_req_offset = wr_idx;
  assign wr_req_data   = transform(mem[rd_ptr[PTR_W-1:0]], mode_lat, add_lat);
  assign wr_count      = wr_cnt;

  // Next-state logic for the run sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_lines == ZERO_OFF) ? DRAIN : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (rd_fire && ((rd_idx + ONE_OFF) == lines)) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (wr_cnt == lines) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Run arguments, indices, counters, credit and the sticky finish flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lines     <= ZERO_OFF;
      mode_lat  <= 2'd0;
      add_lat   <= 32'd0;
      rd_idx    <= ZERO_OFF;
      wr_idx    <= ZERO_OFF;
      wr_cnt    <= ZERO_OFF;
      in_flight <= ZERO_CNT;
      finish    <= 1'b0;
    end else if (launch) begin
      lines     <= num_lines;
      mode_lat  <= mode;
      add_lat   <= add_value;
      rd_idx    <= ZERO_OFF;
      wr_idx    <= ZERO_OFF;
      wr_cnt    <= ZERO_OFF;
      in_flight <= ZERO_CNT;
      finish    <= 1'b0;
    end else begin
      if (rd_fire) begin
        rd_idx <= rd_idx + ONE_OFF;
      end
      if (wr_fire) begin
        wr_idx <= wr_idx + ONE_OFF;
      end
      if (wr_rsp_valid && busy) begin
        wr_cnt <= wr_cnt + ONE_OFF;
      end
      if (done) begin
        finish <= 1'b1;
      end
      case ({rd_fire, wr_fire})
        2'b10:   in_flight <= in_flight + ONE_CNT;
        2'b01:   in_flight <= in_flight - ONE_CNT;
        default: in_flight <= in_flight;
      endcase
    end
  end

  // FIFO pointers; extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= ZERO_CNT;
      rd_ptr <= ZERO_CNT;
    end else if (launch) begin
      wr_ptr <= ZERO_CNT;
      rd_ptr <= ZERO_CNT;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE_CNT;
      end
      if (wr_fire) begin
        rd_ptr <= rd_ptr + ONE_CNT;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= rd_rsp_data;
    end
  end

endmodule
